// File: rtl/serial_bus_master_port.sv
// serial_bus_master_port: initiator-side endpoint of the serial bus.
// Takes one parallel read/write request, sends the control frame and write
// data serially on control/wD/valid, and collects read data from rD/ready.
// Optional feature macro: SMASTER_TIMEOUT_EN bounds every handshake wait by
// TIMEOUT_CYCLES and sends the abort code when the bound is reached.
module serial_bus_master_port #(
  parameter int SLAVES         = 3,
  parameter int DATA_WIDTH     = 32,
  parameter int S_ID_WIDTH     = $clog2(SLAVES + 1),
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  req_valid,
  input  logic                  req_rw,
  input  logic [S_ID_WIDTH-1:0] req_slave_id,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  control,
  output logic                  wD,
  output logic                  valid,
  input  logic                  rD,
  input  logic                  ready
);

  localparam int CON   = 4 + S_ID_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [3:0] {
    IDLE, CTRL, WACK, WDATA, RACK, RDATA, RDONE, ABORT, DONE
  } state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [CON-1:0]        frame, frame_nxt;
  logic [DATA_WIDTH-1:0] wbuf, wbuf_nxt;
  logic [DATA_WIDTH-1:0] cap, cap_nxt;
  logic                  rw_q, rw_nxt;
  logic                  seen_low, seen_low_nxt;
  logic                  control_nxt, wd_nxt, valid_nxt;
  logic                  resp_valid_nxt, resp_err_nxt;
  logic [DATA_WIDTH-1:0] resp_rdata_nxt;
  logic                  tmr_expired;

`ifdef SMASTER_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] tmr;

  assign tmr_expired = (tmr == TMR_W'(TIMEOUT_CYCLES - 1));

  // Wait timer: cleared on every state change and every captured read bit, counts while waiting
  always_ff @(posedge clk) begin
    if (!rstN) begin
      tmr <= '0;
    end else if ((state_nxt != state) || (state == RDATA && ready)) begin
      tmr <= '0;
    end else if (state == WACK || state == RACK || state == RDATA) begin
      tmr <= tmr + 1'b1;
    end
  end
`else
  assign tmr_expired = 1'b0;
`endif

  // Next-state and next-output logic; every output is registered from these values
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    frame_nxt      = frame;
    wbuf_nxt       = wbuf;
    cap_nxt        = cap;
    rw_nxt         = rw_q;
    seen_low_nxt   = seen_low;
    control_nxt    = 1'b0;
    wd_nxt         = 1'b0;
    valid_nxt      = 1'b0;
    resp_valid_nxt = 1'b0;
    resp_err_nxt   = 1'b0;
    resp_rdata_nxt = resp_rdata;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          rw_nxt      = req_rw;
          wbuf_nxt    = req_wdata;
          control_nxt = 1'b1;
          frame_nxt   = {2'b11, req_slave_id, req_rw, 1'b0};
          cnt_nxt     = CNT_W'(1);
          state_nxt   = CTRL;
        end
      end
      CTRL: begin
        if (cnt == CNT_W'(CON)) begin
          state_nxt    = rw_q ? WACK : RACK;
          seen_low_nxt = 1'b0;
          cnt_nxt      = '0;
        end else begin
          control_nxt = frame[CON-1];
          frame_nxt   = {frame[CON-2:0], 1'b0};
          cnt_nxt     = cnt + 1'b1;
        end
      end
      WACK: begin
        if (ready && seen_low) begin
          state_nxt = WDATA;
          valid_nxt = 1'b1;
          wd_nxt    = wbuf[DATA_WIDTH-1];
          wbuf_nxt  = {wbuf[DATA_WIDTH-2:0], 1'b0};
          cnt_nxt   = CNT_W'(1);
        end else if (tmr_expired) begin
          state_nxt   = ABORT;
          control_nxt = 1'b1;
          cnt_nxt     = '0;
        end else if (!ready) begin
          seen_low_nxt = 1'b1;
        end
      end
      WDATA: begin
        if (cnt == CNT_W'(DATA_WIDTH)) begin
          state_nxt      = DONE;
          resp_valid_nxt = 1'b1;
        end else begin
          valid_nxt = 1'b1;
          wd_nxt    = wbuf[DATA_WIDTH-1];
          wbuf_nxt  = {wbuf[DATA_WIDTH-2:0], 1'b0};
          cnt_nxt   = cnt + 1'b1;
        end
      end
      RACK: begin
        if (!ready) begin
          state_nxt = RDATA;
          cnt_nxt   = '0;
        end else if (tmr_expired) begin
          state_nxt   = ABORT;
          control_nxt = 1'b1;
          cnt_nxt     = '0;
        end
      end
      RDATA: begin
        if (ready) begin
          cap_nxt = {cap[DATA_WIDTH-2:0], rD};
          if (cnt == CNT_W'(DATA_WIDTH - 1)) begin
            state_nxt = RDONE;
            valid_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end else if (tmr_expired) begin
          state_nxt   = ABORT;
          control_nxt = 1'b1;
          cnt_nxt     = '0;
        end
      end
      RDONE: begin
        state_nxt      = DONE;
        resp_valid_nxt = 1'b1;
        resp_rdata_nxt = cap;
      end
      ABORT: begin
        if (cnt == CNT_W'(2)) begin
          state_nxt      = DONE;
          resp_valid_nxt = 1'b1;
          resp_err_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, datapath and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state      <= IDLE;
      cnt        <= '0;
      frame      <= '0;
      wbuf       <= '0;
      cap        <= '0;
      rw_q       <= 1'b0;
      seen_low   <= 1'b0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      control    <= 1'b0;
      wD         <= 1'b0;
      valid      <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      frame      <= frame_nxt;
      wbuf       <= wbuf_nxt;
      cap        <= cap_nxt;
      rw_q       <= rw_nxt;
      seen_low   <= seen_low_nxt;
      req_ready  <= (state_nxt == IDLE);
      resp_valid <= resp_valid_nxt;
      resp_err   <= resp_err_nxt;
      resp_rdata <= resp_rdata_nxt;
      control    <= control_nxt;
      wD         <= wd_nxt;
      valid      <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_serial_bus_master_port.sv
// tb_serial_bus_master_port: directed bench for serial_bus_master_port.
// A queue-driven slave model drives ready/rD on the falling edge; entry i of
// the queue is sampled by the DUT at the i-th rising edge after it is loaded.
// Define SMASTER_TIMEOUT_EN for both files to exercise the abort path.
module tb_serial_bus_master_port;

  localparam int DW = 32;

  logic          clk;
  logic          rstN;
  logic          req_valid;
  logic          req_rw;
  logic [1:0]    req_slave_id;
  logic [DW-1:0] req_wdata;
  logic          req_ready;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;
  logic          control;
  logic          wD;
  logic          valid;
  logic          rD;
  logic          ready;

  int n_vec = 0;
  int n_err = 0;

  logic [1:0] sq[$];

  logic          ctl_hist [0:255];
  int            r_edge, r_nvalid, r_last, r_rhigh;
  logic [DW-1:0] r_wword, r_rdata;
  logic          r_err;
  logic [5:0]    snap_flags;
  logic [DW-1:0] snap_rdata;

  serial_bus_master_port #(
    .SLAVES(3),
    .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rstN(rstN),
    .req_valid(req_valid),
    .req_rw(req_rw),
    .req_slave_id(req_slave_id),
    .req_wdata(req_wdata),
    .req_ready(req_ready),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .control(control),
    .wD(wD),
    .valid(valid),
    .rD(rD),
    .ready(ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    ready = 1'b1;
    rD    = 1'b0;
    forever begin
      @(negedge clk);
      if (sq.size() > 0) begin
        {ready, rD} = sq.pop_front();
      end else begin
        ready = 1'b1;
        rD    = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input int n, input logic r, input logic d);
    for (int i = 0; i < n; i++) sq.push_back({r, d});
  endtask

  task automatic push_bits(input logic [DW-1:0] w, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) sq.push_back({1'b1, w[i]});
  endtask

  task automatic start_req(input logic rw, input logic [1:0] id, input logic [DW-1:0] wdata);
    req_valid    = 1'b1;
    req_rw       = rw;
    req_slave_id = id;
    req_wdata    = wdata;
  endtask

  // Runs one transaction from the accepting edge, recording what the DUT shows after each edge
  task automatic run_txn(input int max_edges, input bit hold, input int reset_at);
    r_edge = -1; r_nvalid = 0; r_last = -1; r_rhigh = 0;
    r_wword = '0; r_rdata = '0; r_err = 1'b0;
    for (int i = 0; i < 256; i++) ctl_hist[i] = 1'b0;
    for (int k = 0; k < max_edges; k++) begin
      tick();
      if (k == 0 && !hold) req_valid = 1'b0;
      if (k < 256) ctl_hist[k] = control;
      if (reset_at >= 0 && k == reset_at + 1) begin
        snap_flags = {req_ready, resp_valid, resp_err, control, wD, valid};
        snap_rdata = resp_rdata;
        rstN = 1'b1;
        break;
      end
      if (valid) begin
        r_nvalid++;
        r_wword = {r_wword[DW-2:0], wD};
        r_last  = k;
      end
      if (req_ready) r_rhigh++;
      if (k == reset_at) rstN = 1'b0;
      if (resp_valid) begin
        r_edge  = k;
        r_err   = resp_err;
        r_rdata = resp_rdata;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    tick(); tick();
    n_vec++;
    if ({req_ready, resp_valid, resp_err, control, wD, valid} !== 6'b100000) begin
      n_err++;
      $display("[TB] FAIL reset_flags: got %b expected %b", {req_ready, resp_valid, resp_err, control, wD, valid}, 6'b100000);
    end
    n_vec++;
    if (resp_rdata !== 32'h0) begin
      n_err++;
      $display("[TB] FAIL reset_rdata: got %h expected %h", resp_rdata, 32'h0);
    end
    rstN = 1'b1;
    tick();
    n_vec++;
    if ({req_ready, control, valid} !== 3'b100) begin
      n_err++;
      $display("[TB] FAIL reset_idle: got %b expected %b", {req_ready, control, valid}, 3'b100);
    end
  endtask

  task automatic test_write();
    logic [5:0] f;
    tick();
    push_n(7, 1'b1, 1'b0);
    push_n(2, 1'b0, 1'b0);
    start_req(1'b1, 2'd2, 32'hA5A50F0F);
    run_txn(100, 1'b0, -1);
    f = '0;
    for (int i = 0; i < 6; i++) f = {f[4:0], ctl_hist[i]};
    n_vec++;
    if ({f, ctl_hist[6]} !== 7'b1111010) begin
      n_err++;
      $display("[TB] FAIL write_frame: got %b expected %b", {f, ctl_hist[6]}, 7'b1111010);
    end
    n_vec++;
    if (r_edge !== 41) begin
      n_err++;
      $display("[TB] FAIL write_latency: got %0d expected %0d", r_edge, 41);
    end
    n_vec++;
    if (r_nvalid !== 32 || r_last !== 40) begin
      n_err++;
      $display("[TB] FAIL write_valid_window: got count %0d last %0d expected count 32 last 40", r_nvalid, r_last);
    end
    n_vec++;
    if (r_wword !== 32'hA5A50F0F) begin
      n_err++;
      $display("[TB] FAIL write_data: got %h expected %h", r_wword, 32'hA5A50F0F);
    end
    n_vec++;
    if (r_err !== 1'b0 || r_rhigh !== 0) begin
      n_err++;
      $display("[TB] FAIL write_resp: got err %b ready_highs %0d expected err 0 ready_highs 0", r_err, r_rhigh);
    end
  endtask

  task automatic test_read();
    logic [5:0] f;
    tick();
    push_n(7, 1'b1, 1'b0);
    push_n(2, 1'b0, 1'b0);
    push_bits(32'hDEADBEEF, 31, 0);
    start_req(1'b0, 2'd1, 32'h0);
    run_txn(100, 1'b0, -1);
    f = '0;
    for (int i = 0; i < 6; i++) f = {f[4:0], ctl_hist[i]};
    n_vec++;
    if (f !== 6'b111010) begin
      n_err++;
      $display("[TB] FAIL read_frame: got %b expected %b", f, 6'b111010);
    end
    n_vec++;
    if (r_edge !== 41) begin
      n_err++;
      $display("[TB] FAIL read_latency: got %0d expected %0d", r_edge, 41);
    end
    n_vec++;
    if (r_rdata !== 32'hDEADBEEF || r_err !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL read_data: got %h err %b expected %h err 0", r_rdata, r_err, 32'hDEADBEEF);
    end
    n_vec++;
    if (r_nvalid !== 1 || r_last !== 40) begin
      n_err++;
      $display("[TB] FAIL read_ack: got count %0d at %0d expected count 1 at 40", r_nvalid, r_last);
    end
  endtask

  task automatic test_read_stall();
    tick();
    push_n(7, 1'b1, 1'b0);
    push_n(1, 1'b0, 1'b0);
    push_bits(32'hDEADBEEF, 31, 20);
    push_n(3, 1'b0, 1'b1);
    push_bits(32'hDEADBEEF, 19, 0);
    start_req(1'b0, 2'd1, 32'h0);
    run_txn(100, 1'b0, -1);
    n_vec++;
    if (r_edge !== 43) begin
      n_err++;
      $display("[TB] FAIL stall_latency: got %0d expected %0d", r_edge, 43);
    end
    n_vec++;
    if (r_rdata !== 32'hDEADBEEF) begin
      n_err++;
      $display("[TB] FAIL stall_data: got %h expected %h", r_rdata, 32'hDEADBEEF);
    end
    n_vec++;
    if (r_nvalid !== 1 || r_last !== 42) begin
      n_err++;
      $display("[TB] FAIL stall_ack: got count %0d at %0d expected count 1 at 42", r_nvalid, r_last);
    end
  endtask

`ifdef SMASTER_TIMEOUT_EN
  task automatic test_timeout();
    tick();
    start_req(1'b1, 2'd0, 32'h00000001);
    run_txn(80, 1'b0, -1);
    n_vec++;
    if ({ctl_hist[21], ctl_hist[22], ctl_hist[23], ctl_hist[24]} !== 4'b0100) begin
      n_err++;
      $display("[TB] FAIL abort_code: got %b expected %b", {ctl_hist[21], ctl_hist[22], ctl_hist[23], ctl_hist[24]}, 4'b0100);
    end
    n_vec++;
    if (r_edge !== 25 || r_err !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL abort_resp: got edge %0d err %b expected edge 25 err 1", r_edge, r_err);
    end
    n_vec++;
    if (r_rdata !== 32'hDEADBEEF || r_nvalid !== 0) begin
      n_err++;
      $display("[TB] FAIL abort_retain: got %h valids %0d expected %h valids 0", r_rdata, r_nvalid, 32'hDEADBEEF);
    end
  endtask
`else
  task automatic test_unbounded_wait();
    int ones;
    tick();
    start_req(1'b1, 2'd0, 32'h00000001);
    run_txn(120, 1'b0, -1);
    ones = 0;
    for (int i = 6; i < 120; i++) if (ctl_hist[i] === 1'b1) ones++;
    n_vec++;
    if (r_edge !== -1 || r_nvalid !== 0 || ones !== 0) begin
      n_err++;
      $display("[TB] FAIL unbounded_wait: got edge %0d valids %0d ctl_ones %0d expected -1 0 0", r_edge, r_nvalid, ones);
    end
    rstN = 1'b0;
    tick();
    rstN = 1'b1;
    n_vec++;
    if ({req_ready, resp_err, control} !== 3'b100) begin
      n_err++;
      $display("[TB] FAIL unbounded_recover: got %b expected %b", {req_ready, resp_err, control}, 3'b100);
    end
  endtask
`endif

  task automatic test_mid_reset();
    tick();
    push_n(7, 1'b1, 1'b0);
    push_n(2, 1'b0, 1'b0);
    start_req(1'b1, 2'd2, 32'hFFFF0000);
    run_txn(100, 1'b0, 19);
    sq.delete();
    n_vec++;
    if (snap_flags !== 6'b100000) begin
      n_err++;
      $display("[TB] FAIL midreset_flags: got %b expected %b", snap_flags, 6'b100000);
    end
    n_vec++;
    if (snap_rdata !== 32'h0) begin
      n_err++;
      $display("[TB] FAIL midreset_rdata: got %h expected %h", snap_rdata, 32'h0);
    end
    tick();
    push_n(7, 1'b1, 1'b0);
    push_n(2, 1'b0, 1'b0);
    start_req(1'b1, 2'd3, 32'h3C3CC3C3);
    run_txn(100, 1'b0, -1);
    n_vec++;
    if (r_edge !== 41 || r_err !== 1'b0 || r_wword !== 32'h3C3CC3C3) begin
      n_err++;
      $display("[TB] FAIL midreset_recover: got edge %0d err %b data %h expected 41 0 %h", r_edge, r_err, r_wword, 32'h3C3CC3C3);
    end
  endtask

  task automatic test_back_to_back();
    tick();
    push_n(7, 1'b1, 1'b0);
    push_n(2, 1'b0, 1'b0);
    start_req(1'b1, 2'd1, 32'h0000FFFF);
    run_txn(100, 1'b1, -1);
    n_vec++;
    if (r_edge !== 41 || r_rhigh !== 0 || r_wword !== 32'h0000FFFF) begin
      n_err++;
      $display("[TB] FAIL b2b_first: got edge %0d ready_highs %0d data %h expected 41 0 %h", r_edge, r_rhigh, r_wword, 32'h0000FFFF);
    end
    tick();
    n_vec++;
    if ({req_ready, resp_valid, control} !== 3'b100) begin
      n_err++;
      $display("[TB] FAIL b2b_gap: got %b expected %b", {req_ready, resp_valid, control}, 3'b100);
    end
    tick();
    n_vec++;
    if ({req_ready, resp_valid, control} !== 3'b001) begin
      n_err++;
      $display("[TB] FAIL b2b_accept: got %b expected %b", {req_ready, resp_valid, control}, 3'b001);
    end
    req_valid = 1'b0;
    rstN = 1'b0;
    tick();
    rstN = 1'b1;
    sq.delete();
  endtask

  initial begin
    rstN         = 1'b0;
    req_valid    = 1'b0;
    req_rw       = 1'b0;
    req_slave_id = 2'd0;
    req_wdata    = '0;
    test_reset();
    test_write();
    test_read();
`ifdef SMASTER_TIMEOUT_EN
    test_timeout();
`else
    test_unbounded_wait();
`endif
    test_mid_reset();
    test_read_stall();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
